// File: rtl/mem_reader_pkg.sv
// Shared types for the burst memory reader.
package mem_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mem_reader.sv
// Burst reader: walks a combinational-read memory from a base address and
// streams the words out over a valid/ready interface.
//
// state    | meaning
// ST_IDLE  | waiting for start_i; captures base and length
// ST_RUN   | words left to fetch; loads whenever the output slot frees up
// ST_DRAIN | final word fetched, waiting for it to be accepted
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    input  logic [AWIDTH:0]   len_i,
    output logic [AWIDTH-1:0] rd_addr_o,
    input  logic [DWIDTH-1:0] rd_data_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [AWIDTH:0]   CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [AWIDTH-1:0]   ptr;
    logic [AWIDTH:0]     remaining;
    logic                load;
    logic                beat;
    logic                accept;

    assign rd_addr_o = ptr;
    assign busy_o    = (state != ST_IDLE);

    always_comb begin
        beat      = valid_o && ready_i;
        load      = (state == ST_RUN) && (remaining != '0) && (!valid_o || ready_i);
        accept    = (state == ST_IDLE) && start_i;
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i && (len_i != '0))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (beat && last_o)
                    state_nxt = ST_IDLE;
                else if (load && (remaining == CNT_ONE))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (beat && last_o)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= '0;
            remaining <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                ptr       <= base_addr_i;
                remaining <= len_i;
                if (len_i == '0)
                    done_o <= 1'b1;
            end
            // A load refills the slot in the same edge a beat leaves it.
            if (load) begin
                data_o    <= rd_data_i;
                valid_o   <= 1'b1;
                last_o    <= (remaining == CNT_ONE);
                ptr       <= ptr + PTR_ONE;
                remaining <= remaining - CNT_ONE;
            end else if (beat) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
            if (beat && last_o)
                done_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: bench-side dual-port memory, directed bursts,
// a monitor that pops expected beats on every handshake.
module tb_mem_reader;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [256];
    assign rd_data = mem[rd_addr];

    mem_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .base_addr_i(base),
        .len_i      (len),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .last_o     (last),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [AW-1:0] nxt;
    } beat_t;

    beat_t sbq[$];
    beat_t e;

    int checks   = 0;
    int failures = 0;
    int beat_cnt = 0;
    int mode     = 0;
    int phase    = 0;

    bit            model_busy = 1'b0;
    bit            exp_done   = 1'b0;
    bit            nxt_done;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready pattern: 0 held high, 1 repeating 1,0,0, 2 random.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                ready = (phase == 0);
                phase = (phase + 1) % 3;
            end
            2: ready = ($urandom_range(0, 1) == 1);
            default: ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            model_busy = 1'b0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("done_o", done, exp_done);
            check("busy_o", busy, model_busy);
            if (prev_stall) begin
                check("stall_valid", valid, 1);
                check("stall_data", data, prev_data);
                check("stall_last", last, prev_last);
                check("stall_addr", rd_addr, prev_addr);
            end
            nxt_done = 1'b0;
            if (valid && ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data 0x%0h with no beat expected at %0t", data, $time);
                end else begin
                    e = sbq.pop_front();
                    check("beat_data", data, e.data);
                    check("beat_last", last, e.last);
                    check("beat_rd_addr", rd_addr, e.nxt);
                    beat_cnt++;
                    if (e.last) begin
                        model_busy = 1'b0;
                        nxt_done   = 1'b1;
                    end
                end
            end else if (!model_busy && start) begin
                if (len != '0)
                    model_busy = 1'b1;
                else
                    nxt_done = 1'b1;
            end
            exp_done   = nxt_done;
            prev_stall = valid && !ready;
            prev_data  = data;
            prev_last  = last;
            prev_addr  = rd_addr;
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input int l, input bit accepted);
        logic [AW-1:0] a;
        beat_t         t;
        start = 1'b1;
        base  = b;
        len   = l[AW:0];
        if (accepted) begin
            for (int i = 0; i < l; i++) begin
                a      = b + i[AW-1:0];
                t.data = 32'h100 + {24'h0, a};
                t.last = (i == l - 1);
                t.nxt  = a + 8'h01;
                sbq.push_back(t);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sbq.size() == 0 && !model_busy && !exp_done) begin
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, sbq.size());
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, valid, 0);
        check({name, "_last"}, last, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_rd_addr"}, rd_addr, 0);
        check({name, "_data"}, data, 0);
    endtask

    initial begin
        int target;
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // base 0x10 len 4, ready high: one idle cycle, four beats back to back
        start_burst(8'h10, 4, 1'b1);
        @(negedge clk);
        check("t1_latency_valid", valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_back_to_back", valid, 1);
        end
        @(negedge clk);
        check("t1_valid_drop", valid, 0);
        check("t1_done", done, 1);
        wait_idle("t1", 50);

        // wrap past the top of memory
        start_burst(8'hFE, 3, 1'b1);
        wait_idle("t2", 50);

        // stalls with ready 1,0,0 repeating
        mode = 1;
        start_burst(8'h20, 5, 1'b1);
        wait_idle("t3", 100);
        mode = 0;

        // zero length: done only
        start_burst(8'h30, 0, 1'b1);
        wait_idle("t4", 20);

        // start while busy is ignored
        start_burst(8'h40, 8, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start_burst(8'h00, 3, 1'b0);
        wait_idle("t5", 50);

        // reset after the second beat of a len-6 burst
        target = beat_cnt + 2;
        start_burst(8'h50, 6, 1'b1);
        for (int i = 0; i < 50 && beat_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_second_beat_seen", beat_cnt, target);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_burst(8'h60, 2, 1'b1);
        wait_idle("t6", 50);

        // full memory from 0x80 with random ready
        mode = 2;
        start_burst(8'h80, 256, 1'b1);
        wait_idle("t7", 2000);
        mode = 0;

        // start issued in the done cycle is accepted
        start_burst(8'h05, 2, 1'b1);
        for (int i = 0; i < 50 && !exp_done; i++) begin
            @(negedge clk);
            #1;
        end
        check("t8_done_expected", exp_done, 1);
        @(posedge clk);
        #1;
        start_burst(8'h07, 2, 1'b1);
        wait_idle("t8", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
